spi_resp_scheduler: RTL and testbench

Controller in the system clock domain that sequences response preparation for the quad-SPI IO bridge. Given a command code latched by the bridge and synchronised into `clk`, it decodes the command and requests a data snapshot from the owning source over a req/ack handshake. It loads the snapshot into a response buffer that the bridge drains during its transmit phase. It also keeps the sticky per-source "new data" flags reported by the status command.

---
 rtl/spi_io_pkg.sv | 34 +++
 rtl/spi_resp_scheduler_resp_buffer.sv | 40 ++++
 rtl/spi_resp_scheduler.sv | 165 ++++++++++++++++
 tb/tb_spi_resp_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_io_pkg.sv
// Shared definitions for the quad-SPI IO bridge and its response scheduler.
package spi_io_pkg;

  // Command codes understood by the device.
  typedef enum logic [7:0] {
    CMD_GET_STATUS0         = 8'h50,
    CMD_KB_GET_PRESSED_KEYS = 8'h51,
    CMD_MOUSE_GET_STATE     = 8'h52
  } command_code_e;

  // Direction flags carried in the command byte.
  localparam int H2D_FLAG_BIT = 7;  // host-to-device data follows
  localparam int D2H_FLAG_BIT = 6;  // device-to-host response follows

  localparam int RESP_BYTES_DEFAULT = 8;
  localparam int SRC_DATA_W         = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_REQ,
    ST_LOAD,
    ST_READY,
    ST_ERROR
  } sched_state_e;

  // Source owning a snapshot command, or -1 when the code is not a source command.
  function automatic int cmd_src_index(input logic [7:0] code);
    if (code == CMD_KB_GET_PRESSED_KEYS) return 0;
    if (code == CMD_MOUSE_GET_STATE)     return 1;
    return -1;
  endfunction

endpackage

// File: rtl/spi_resp_scheduler_resp_buffer.sv
// Byte-addressed response buffer: 64-bit parallel load, single-byte load and
// a read port that returns zero beyond the valid length.
module resp_buffer #(
  parameter int BYTES = 8,
  parameter int IW    = $clog2(BYTES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_all,
  input  logic [BYTES*8-1:0] wr_all_data,
  input  logic               wr_byte,
  input  logic [IW-1:0]      wr_idx,
  input  logic [7:0]         wr_data,
  input  logic [IW-1:0]      rd_idx,
  input  logic [IW:0]        rd_len,
  output logic [7:0]         rd_data
);

  logic [BYTES-1:0][7:0] mem_q, mem_d;

  // Next buffer contents: full load wins over a single-byte write.
  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < BYTES; b++) begin
      if (wr_all)
        mem_d[b] = wr_all_data[b*8 +: 8];
      else if (wr_byte && (wr_idx == IW'(b)))
        mem_d[b] = wr_data;
    end
  end

  // Buffer register bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  assign rd_data = ({1'b0, rd_idx} < rd_len) ? mem_q[rd_idx] : 8'h00;

endmodule

// File: rtl/spi_resp_scheduler.sv
// Response scheduler: decodes a bridge command, fetches a source snapshot over
// req/ack, fills the response buffer and keeps sticky per-source pending flags.
module spi_resp_scheduler
  import spi_io_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int RESP_BYTES  = RESP_BYTES_DEFAULT,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  input  logic [7:0]              cmd_code,
  input  logic                    cmd_abort,
  output logic                    cmd_busy,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [3:0]              resp_len,
  input  logic [2:0]              resp_rd_idx,
  output logic [7:0]              resp_rd_data,
  output logic [NUM_SRC-1:0]      src_req,
  input  logic [NUM_SRC-1:0]      src_ack,
  input  logic [NUM_SRC*64-1:0]   src_data,
  input  logic [NUM_SRC*4-1:0]    src_len,
  input  logic [NUM_SRC-1:0]      src_event
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  sched_state_e          state_q, state_d;
  logic [7:0]            code_q, code_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            len_q, len_d;
  logic [NUM_SRC-1:0]    pend_q, pend_d;
  logic                  status_q, status_d;

  logic                  buf_wr_all, buf_wr_byte;
  logic [7:0]            buf_byte_data;

  logic [NUM_SRC-1:0][SRC_DATA_W-1:0] src_data_a;
  logic [NUM_SRC-1:0][3:0]            src_len_a;
  logic [SRC_DATA_W-1:0]              sel_data;
  logic [3:0]                         sel_len;

  assign src_data_a = src_data;
  assign src_len_a  = src_len;
  assign sel_data   = src_data_a[sel_q];
  assign sel_len    = src_len_a[sel_q];

  // Next-state, buffer-load and pending-flag logic.
  always_comb begin
    int idx;
    state_d       = state_q;
    code_d        = code_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    status_d      = status_q;
    pend_d        = pend_q | src_event;  // events are never lost, whatever the state
    buf_wr_all    = 1'b0;
    buf_wr_byte   = 1'b0;
    buf_byte_data = 8'(pend_q);
    idx           = cmd_src_index(code_q);

    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            code_d  = cmd_code;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (code_q == CMD_GET_STATUS0) begin
            buf_wr_byte = 1'b1;
            len_d       = 4'd1;
            status_d    = 1'b1;
            // Every bit captured is cleared; only a same-cycle event survives.
            pend_d      = src_event;
            // Status passes through LOAD so it answers on the third cycle.
            state_d     = ST_LOAD;
          end else if (idx >= 0 && idx < NUM_SRC) begin
            sel_d    = SW'(idx);
            cnt_d    = '0;
            status_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            len_d   = 4'd0;
            state_d = ST_ERROR;
          end
        end
        ST_REQ: begin
          cnt_d = cnt_q + CW'(1);
          if (src_ack[sel_q]) begin
            // Snapshot is only guaranteed valid alongside the ack, so sample it now.
            buf_wr_all = 1'b1;
            len_d      = (sel_len > 4'(RESP_BYTES)) ? 4'(RESP_BYTES) : sel_len;
            state_d    = ST_LOAD;
          end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            len_d   = 4'd0;
            state_d = ST_ERROR;
          end
        end
        ST_LOAD: begin
          if (!status_q)
            pend_d[sel_q] = src_event[sel_q];
          state_d = ST_READY;
        end
        ST_READY, ST_ERROR: state_d = state_q;
        default:            state_d = ST_IDLE;
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      pend_q   <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      pend_q   <= pend_d;
      status_q <= status_d;
    end
  end

  // One-hot request, withdrawn in the same cycle as an abort.
  always_comb begin
    src_req = '0;
    if (state_q == ST_REQ && !cmd_abort)
      src_req[sel_q] = 1'b1;
  end

  assign cmd_busy   = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_READY || state_q == ST_ERROR) && !cmd_abort;
  assign resp_err   = (state_q == ST_ERROR) && !cmd_abort;
  assign resp_len   = len_q;

  resp_buffer #(.BYTES(RESP_BYTES)) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_all      (buf_wr_all),
    .wr_all_data (sel_data[RESP_BYTES*8-1:0]),
    .wr_byte     (buf_wr_byte),
    .wr_idx      ('0),
    .wr_data     (buf_byte_data),
    .rd_idx      (resp_rd_idx),
    .rd_len      (len_q),
    .rd_data     (resp_rd_data)
  );

endmodule

// File: tb/tb_spi_resp_scheduler.sv
// Scoreboard bench for spi_resp_scheduler: stimulus pushes expected responses,
// an independent monitor pops and checks each response as it appears.
module tb_spi_resp_scheduler;

  localparam int NUM_SRC     = 2;
  localparam int RESP_BYTES  = 8;
  localparam int ACK_TIMEOUT = 255;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic [7:0]            cmd_code = 8'h00;
  logic                  cmd_abort = 1'b0;
  logic                  cmd_busy, resp_valid, resp_err;
  logic [3:0]            resp_len;
  logic [2:0]            resp_rd_idx = 3'd0;
  logic [7:0]            resp_rd_data;
  logic [NUM_SRC-1:0]    src_req;
  logic [NUM_SRC-1:0]    src_ack = '0;
  logic [NUM_SRC*64-1:0] src_data = '0;
  logic [NUM_SRC*4-1:0]  src_len = '0;
  logic [NUM_SRC-1:0]    src_event = '0;

  spi_resp_scheduler #(.NUM_SRC(NUM_SRC), .RESP_BYTES(RESP_BYTES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_abort(cmd_abort), .cmd_busy(cmd_busy), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_len(resp_len), .resp_rd_idx(resp_rd_idx),
    .resp_rd_data(resp_rd_data), .src_req(src_req), .src_ack(src_ack),
    .src_data(src_data), .src_len(src_len), .src_event(src_event)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        err;
    logic [3:0]  len;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [NUM_SRC-1:0] pend_m = '0;  // reference view of the sticky pending flags

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on the first cycle of each response, compare against the queue head.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev = 1'b0;
      else begin
        if (resp_valid && !prev) begin
          if (exp_q.size() == 0) chk("unexpected_resp_queue_size", 64'(exp_q.size()), 64'd1);
          else begin
            e = exp_q.pop_front();
            chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            chk("resp_err", 64'(resp_err), 64'(e.err));
            chk("resp_len", 64'(resp_len), 64'(e.len));
            chk("busy_during_resp", 64'(cmd_busy), 64'd1);
            for (int i = 0; i < 8; i++) begin
              logic [7:0] eb;
              eb = (i < int'(e.len)) ? e.data[i*8 +: 8] : 8'h00;
              resp_rd_idx = 3'(i);
              #1;
              chk($sformatf("resp_byte%0d", i), 64'(resp_rd_data), 64'(eb));
            end
          end
        end
        prev = resp_valid;
      end
    end
  end

  task automatic issue(input logic [7:0] code, output int n);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_code  = code;
    n = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_code  = 8'($urandom);
  endtask

  task automatic pulse_event(input logic [NUM_SRC-1:0] mask);
    @(posedge clk); #1;
    src_event = mask;
    pend_m    = pend_m | mask;
    @(posedge clk); #1;
    src_event = '0;
  endtask

  // Wait for the response, optionally poke a stray cmd_valid, then abort.
  task automatic finish_resp(input string name, input bit stray);
    int k;
    k = 0;
    while (!resp_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!resp_valid) chk({name, "_resp_wait"}, 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    if (stray) begin
      cmd_valid = 1'b1;  // ignored outside IDLE
      cmd_code  = 8'h50;
    end
    @(posedge clk); #1;
    cmd_abort = 1'b1;    // a simultaneous cmd_valid must also lose to the abort
    @(negedge clk);
    chk({name, "_abort_clears_valid"}, 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input int s, output int r);
    int k;
    k = 0;
    while (!src_req[s] && k < 10) begin
      @(negedge clk);
      k++;
    end
    r = cyc;
    if (!src_req[s]) chk("req_wait", 64'(src_req), 64'(1 << s));
  endtask

  task automatic do_status(input bit stray);
    int n;
    issue(8'h50, n);
    exp_q.push_back('{1'b0, 4'd1, 64'(pend_m), n + 3});
    pend_m = '0;
    finish_resp("status", stray);
  endtask

  task automatic do_src(input int s, input int d, input bit junk, input bit load_evt,
                        input logic [63:0] data, input logic [3:0] len);
    int n, r;
    issue(8'h51 + 8'(s), n);
    wait_req(s, r);
    chk("req_rise_cycle", 64'(r), 64'(n + 2));
    chk("req_onehot", 64'(src_req), 64'(1 << s));
    for (int k = 0; k < d; k++) begin
      if (k == 0 && junk) src_ack[1 - s] = 1'b1;
      @(posedge clk); #1;
      src_ack = '0;
    end
    src_data = {$urandom, $urandom, $urandom, $urandom};
    src_len  = 8'($urandom);
    src_data[s*64 +: 64] = data;
    src_len[s*4 +: 4]    = len;
    src_ack[s] = 1'b1;
    exp_q.push_back('{1'b0, (len > 4'd8) ? 4'd8 : len, data, cyc + 2});
    @(posedge clk); #1;
    src_ack = '0;
    if (load_evt) src_event[s] = 1'b1;
    pend_m[s] = load_evt;
    @(posedge clk); #1;
    src_event = '0;
    finish_resp("src", 1'b0);
  endtask

  task automatic do_undef(input logic [7:0] code);
    int n;
    issue(code, n);
    exp_q.push_back('{1'b1, 4'd0, 64'd0, n + 2});
    @(negedge clk);
    chk("undef_req_decode", 64'(src_req), 64'd0);
    @(negedge clk);
    chk("undef_req_error", 64'(src_req), 64'd0);
    finish_resp("undef", 1'b0);
  endtask

  task automatic do_abort_req(input int s);
    int n, r;
    issue(8'h51 + 8'(s), n);
    wait_req(s, r);
    @(posedge clk); #1;
    cmd_abort = 1'b1;
    @(negedge clk);
    chk("abort_drops_req", 64'(src_req), 64'd0);
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_low", 64'(cmd_busy), 64'd0);
  endtask

  initial begin
    int n, r, sel;
    logic [7:0] uc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(cmd_busy), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_len", 64'(resp_len), 64'd0);
    chk("rst_req", 64'(src_req), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed cases.
    pulse_event(2'b01);
    do_status(1'b0);                      // 0x01
    do_status(1'b0);                      // 0x00 after clear
    do_src(0, 4, 1'b0, 1'b0, 64'h0000_0000_0004_0A0B, 4'd3);
    issue(8'h52, n);                      // mouse never acks
    wait_req(1, r);
    exp_q.push_back('{1'b1, 4'd0, 64'd0, r + ACK_TIMEOUT});
    finish_resp("timeout", 1'b0);
    do_undef(8'h7F);
    do_abort_req(0);
    do_status(1'b0);
    do_src(1, 2, 1'b1, 1'b1, 64'h1122_3344_5566_7788, 4'd12);
    do_status(1'b0);                      // 0x02 kept by the LOAD-cycle event

    // Reset mid-operation clears pending flags and outputs at once.
    pulse_event(2'b11);
    issue(8'h51, n);
    wait_req(0, r);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_req", 64'(src_req), 64'd0);
    chk("midrst_busy", 64'(cmd_busy), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pend_m = '0;
    do_status(1'b0);

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) pulse_event(2'($urandom_range(1, 3)));
      case ($urandom_range(0, 8))
        0, 1, 2: do_status(1'($urandom));
        3, 4, 5, 6: begin
          sel = $urandom_range(0, 1);
          do_src(sel, $urandom_range(0, 12), 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, 4'($urandom));
        end
        7: begin
          uc = 8'($urandom);
          if (uc >= 8'h50 && uc <= 8'h52) uc = 8'hA5;
          do_undef(uc);
        end
        default: do_abort_req($urandom_range(0, 1));
      endcase
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
